// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - State encoding and default sizes shared by the APB master files
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W         = 8;
    localparam int APB_DATA_W         = 8;
    localparam int APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - Counts stalled ACCESS cycles; terminal marks the LIMIT-th one
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (count_en && !terminal) begin
            count <= count + CW'(1);
        end
    end

    // High during the stalled cycle that would be number LIMIT
    assign terminal = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - Single-outstanding APB master; optional ACCESS timeout via APB_MASTER_TIMEOUT_EN
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_t        state, state_next;
    logic              cmd_ready_next, rsp_valid_next, psel_next, penable_next, pwrite_next;
    logic [ADDR_W-1:0] paddr_next;
    logic [DATA_W-1:0] pwdata_next, rsp_rdata_next;
    logic              accept;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic timer_terminal;
    logic rsp_timeout_next;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (pclk),
        .resetn   (preset),
        .clear    (accept),
        .count_en ((state == ACCESS) && !pready),
        .terminal (timer_terminal)
    );

    always_ff @(posedge pclk) begin
        if (!preset) begin
            rsp_timeout <= 1'b0;
        end else begin
            rsp_timeout <= rsp_timeout_next;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign rsp_timeout        = 1'b0;
`endif

    // Next values for every registered output are decided here so nothing leaves combinationally
    always_comb begin
        state_next     = state;
        cmd_ready_next = 1'b0;
        rsp_valid_next = 1'b0;
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        pwrite_next    = pwrite;
        paddr_next     = paddr;
        pwdata_next    = pwdata;
        rsp_rdata_next = rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_timeout_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = SETUP;
                    psel_next   = 1'b1;
                    pwrite_next = cmd_write;
                    paddr_next  = cmd_addr;
                    pwdata_next = cmd_wdata;
                end else begin
                    cmd_ready_next = 1'b1;
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_next     = IDLE;
                    cmd_ready_next = 1'b1;
                    rsp_valid_next = 1'b1;
                    if (!pwrite) begin
                        rsp_rdata_next = prdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                end else if (timer_terminal) begin
                    state_next       = IDLE;
                    cmd_ready_next   = 1'b1;
                    rsp_valid_next   = 1'b1;
                    rsp_timeout_next = 1'b1;
                    rsp_rdata_next   = '0;
`endif
                end else begin
                    psel_next    = 1'b1;
                    penable_next = 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            state     <= state_next;
            cmd_ready <= cmd_ready_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            psel      <= psel_next;
            penable   <= penable_next;
            pwrite    <= pwrite_next;
            paddr     <= paddr_next;
            pwdata    <= pwdata_next;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - Scoreboard bench for apb_master with a 64-entry APB completer model
module tb_apb_master;

    localparam int T = 16;

    logic       pclk = 1'b0;
    logic       preset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = 8'h00;
    logic       pready = 1'b0;

    always #5 pclk = ~pclk;

    apb_master #(
        .ADDR_W         (8),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready)
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic       tmo;
        int         acc;
        int         nacc;
    } exp_t;

    exp_t       sbq[$];
    int         waitq[$];
    logic [7:0] ref_mem[64];
    logic [7:0] mem[64];
    logic [7:0] last_rd = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Completer: memory updates on the clock, pready/prdata set half a cycle ahead
    int cur_wait = 0;
    int acc_cnt = 0;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (preset && psel && penable && pready && pwrite) begin
            mem[paddr[5:0]] <= pwdata;
        end
    end

    always @(negedge pclk) begin
        if (psel && !penable) begin
            cur_wait = (waitq.size() > 0) ? waitq.pop_front() : 0;
            acc_cnt  = 0;
            pready   = 1'($urandom_range(0, 1));
        end else if (psel && penable) begin
            pready  = (cur_wait >= 0) && (acc_cnt >= cur_wait);
            acc_cnt = acc_cnt + 1;
        end else begin
            pready = 1'($urandom_range(0, 1));
        end
        prdata = mem[paddr[5:0]];
    end

    // Monitor: protocol shape, held bus fields and response scoreboard
    logic       prev_psel = 1'b0;
    int         nacc = 0;
    logic [16:0] last_bus = '0;

    always @(negedge pclk) begin
        exp_t e;
        if (!preset) begin
            prev_psel = 1'b0;
            nacc      = 0;
            last_bus  = '0;
        end else begin
            if (psel) begin
                if (sbq.size() == 0) begin
                    check("spurious_xfer", 1, 0);
                end else begin
                    check("apb_fields", {pwrite, paddr, pwdata}, {sbq[0].w, sbq[0].a, sbq[0].d});
                    if (!penable) begin
                        check("setup_entry", prev_psel, 0);
                        nacc     = 0;
                        last_bus = {sbq[0].w, sbq[0].a, sbq[0].d};
                    end else begin
                        check("access_entry", prev_psel, 1);
                        nacc++;
                    end
                end
            end else begin
                check("idle_hold", {pwrite, paddr, pwdata, penable}, {last_bus, 1'b0});
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rd);
                    check("rsp_timeout", rsp_timeout, e.tmo);
                    check("access_len", nacc, e.nacc);
                    check("rsp_latency", cyc - e.acc, e.nacc + 1);
                end
            end
            prev_psel = psel;
        end
    end

    // Driver; waits < 0 means the completer never raises pready
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, output int acc);
        int   n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc       = -1;
        n         = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("accept_wait", cmd_ready, 1);
        if (cmd_ready) begin
            acc   = cyc + 1;
            e.w   = w;
            e.a   = a;
            e.d   = d;
            e.acc = acc;
            if (waits < 0) begin
                e.tmo  = 1'b1;
                e.rd   = 8'h00;
                e.nacc = T;
                last_rd = 8'h00;
            end else begin
                e.tmo  = 1'b0;
                e.nacc = waits + 1;
                if (w) begin
                    ref_mem[a[5:0]] = d;
                    e.rd = last_rd;
                end else begin
                    e.rd    = ref_mem[a[5:0]];
                    last_rd = e.rd;
                end
            end
            sbq.push_back(e);
            waitq.push_back(waits);
            @(negedge pclk);
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        preset    = 1'b0;
        cmd_valid = 1'b0;
        sbq.delete();
        waitq.delete();
        last_rd = 8'h00;
        repeat (n) @(negedge pclk);
        check("reset_state",
              {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_timeout, cmd_ready}, 0);
        preset = 1'b1;
        @(negedge pclk);
        check("ready_after_release", cmd_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        while (sbq.size() > 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        check("drain", sbq.size(), 0);
        @(negedge pclk);
    endtask

    initial begin
        int acc1, acc2, acc3, n;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        do_reset(3);

        send(1'b1, 8'h05, 8'hA5, 0, acc1);
        drain();
        send(1'b0, 8'h05, 8'h3C, 0, acc1);
        drain();
        check("readback_model", ref_mem[5], 8'hA5);

        send(1'b1, 8'h30, 8'h96, 4, acc1);
        drain();
        send(1'b0, 8'h30, 8'h00, 4, acc1);
        drain();

        send(1'b1, 8'h11, 8'h42, 0, acc1);
        send(1'b1, 8'h12, 8'h43, 1, acc2);
        send(1'b0, 8'h11, 8'h00, 0, acc3);
        drain();
        check("b2b_accept_0w", acc2, acc1 + 3);
        check("b2b_accept_1w", acc3, acc2 + 4);

        for (int i = 0; i < 40; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(0, 3), acc1);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                cmd_valid = 1'b0;
                repeat (n) @(negedge pclk);
            end
        end
        drain();

        send(1'b0, 8'h10, 8'h77, 10, acc1);
        cmd_valid = 1'b0;
        n = 0;
        while (!penable && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("reach_access", penable, 1);
        do_reset(1);
        repeat (3) @(negedge pclk);

`ifdef APB_MASTER_TIMEOUT_EN
        send(1'b1, 8'h22, 8'h5A, -1, acc1);
        drain();
        check("timeout_psel", {psel, penable}, 0);
        send(1'b0, 8'h22, 8'h00, 0, acc1);
        drain();
`endif

        send(1'b0, 8'h05, 8'h00, 2, acc1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
